// File: rtl/iob_ram_sp_be_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  iob_ram_sp_be_ctrl_pkg
//  Shared state encoding and width helpers for the IOb single-port RAM ctrl.
//  Rev 1.0
// ============================================================================
package iob_ram_sp_be_ctrl_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_RUN   = 1'b1;

    function automatic int wstrb_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int byte_off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_ram_sp_be_ctrl_rsp.sv
`default_nettype none
// ============================================================================
//  iob_ram_sp_be_ctrl_rsp
//  Read response path: RAM bypass plus hold register under host backpressure.
//  Rev 1.0
// ============================================================================
module iob_ram_sp_be_ctrl_rsp #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_accept_i,
    input  logic              rready_i,
    input  logic [DATA_W-1:0] mem_d_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o
);

    logic              inflight_q, inflight_d;
    logic              held_q, held_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // RAM output is only valid the cycle after the read; capture it if the
    // host is not ready, since the RAM may drive anything afterwards.
    always_comb begin
        inflight_d = rd_accept_i;
        held_d     = held_q;
        hold_d     = hold_q;
        if (inflight_q && !rready_i) begin
            held_d = 1'b1;
            hold_d = mem_d_i;
        end else if (held_q && rready_i) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            held_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            held_q     <= held_d;
            hold_q     <= hold_d;
        end
    end

    assign rvalid_o = !rst_i && (inflight_q || held_q);
    assign rdata_o  = held_q ? hold_q : mem_d_i;
    assign stall_o  = rvalid_o && !rready_i;

endmodule
`default_nettype wire

// File: rtl/iob_ram_sp_be_ctrl.sv
`default_nettype none
// ============================================================================
//  iob_ram_sp_be_ctrl
//  IOb native to single-port byte-enable RAM controller with clear engine.
//  Rev 1.0
// ============================================================================
module iob_ram_sp_be_ctrl
    import iob_ram_sp_be_ctrl_pkg::*;
#(
    parameter int                      ADDR_W         = 10,
    parameter int                      DATA_W         = 32,
    parameter bit                      CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]       INIT_VAL       = '0
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       iob_valid_i,
    input  logic [ADDR_W+byte_off_width(DATA_W)-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]                          iob_wdata_i,
    input  logic [wstrb_width(DATA_W)-1:0]             iob_wstrb_i,
    output logic                                       iob_ready_o,
    output logic                                       iob_rvalid_o,
    output logic [DATA_W-1:0]                          iob_rdata_o,
    input  logic                                       iob_rready_i,
    input  logic                                       init_i,
    output logic                                       init_done_o,
    output logic                                       mem_en_o,
    output logic [wstrb_width(DATA_W)-1:0]             mem_we_o,
    output logic [ADDR_W-1:0]                          mem_addr_o,
    output logic [DATA_W-1:0]                          mem_d_o,
    input  logic [DATA_W-1:0]                          mem_d_i
);

    localparam int          WSTRB_W     = wstrb_width(DATA_W);
    localparam int          BYTE_OFF_W  = byte_off_width(DATA_W);
    localparam int          DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
    localparam state_t      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                armed_q, armed_d;

    logic                w_run;
    logic                w_clearing;
    logic                w_init_req;
    logic                w_accept;
    logic                w_rd_accept;
    logic                w_stall;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_word_addr = iob_addr_i[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];

    generate
        if (BYTE_OFF_W > 0) begin : g_byte_off
            logic unused_byte_off;
            assign unused_byte_off = ^iob_addr_i[BYTE_OFF_W-1:0];
        end
    endgenerate

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            armed_q   <= armed_d;
        end
    end

    // A held-high init_i triggers once; it must be seen low to re-arm.
    assign w_init_req = init_i && armed_q && (state_q == ST_RUN);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        armed_d   = armed_q || !init_i;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (w_init_req) begin
                    pending_d = 1'b1;
                    armed_d   = 1'b0;
                end
                if ((pending_q || w_init_req) && !iob_rvalid_o) begin
                    state_d   = ST_CLEAR;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Output logic
    assign w_run       = !rst_i && (state_q == ST_RUN);
    assign w_clearing  = !rst_i && (state_q == ST_CLEAR);
    assign iob_ready_o = w_run && !w_stall && !pending_q && !w_init_req;
    assign w_accept    = iob_valid_i && iob_ready_o;
    assign w_rd_accept = w_accept && (iob_wstrb_i == '0);
    assign init_done_o = w_run;

    always_comb begin
        mem_en_o   = 1'b0;
        mem_we_o   = '0;
        mem_addr_o = w_word_addr;
        mem_d_o    = iob_wdata_i;
        if (w_clearing) begin
            mem_en_o   = 1'b1;
            mem_we_o   = {WSTRB_W{1'b1}};
            mem_addr_o = cnt_q;
            mem_d_o    = INIT_VAL;
        end else if (w_accept) begin
            mem_en_o = 1'b1;
            mem_we_o = iob_wstrb_i;
        end
    end

    iob_ram_sp_be_ctrl_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_accept_i (w_rd_accept),
        .rready_i    (iob_rready_i),
        .mem_d_i     (mem_d_i),
        .rvalid_o    (iob_rvalid_o),
        .rdata_o     (iob_rdata_o),
        .stall_o     (w_stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_sp_be_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_iob_ram_sp_be_ctrl
//  Directed self-checking bench with a behavioural byte-enable RAM model.
//  Rev 1.0
// ============================================================================
module tb_iob_ram_sp_be_ctrl;

    localparam int          ADDR_W = 4;
    localparam int          DATA_W = 32;
    localparam logic [31:0] INIT_V = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        iob_valid_i;
    logic [5:0]  iob_addr_i;
    logic [31:0] iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_ready_o;
    logic        iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic        iob_rready_i;
    logic        init_i;
    logic        init_done_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_d_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_ram_sp_be_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .CLEAR_ON_RESET (1'b1),
        .INIT_VAL       (INIT_V)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .iob_valid_i  (iob_valid_i),
        .iob_addr_i   (iob_addr_i),
        .iob_wdata_i  (iob_wdata_i),
        .iob_wstrb_i  (iob_wstrb_i),
        .iob_ready_o  (iob_ready_o),
        .iob_rvalid_o (iob_rvalid_o),
        .iob_rdata_o  (iob_rdata_o),
        .iob_rready_i (iob_rready_i),
        .init_i       (init_i),
        .init_done_o  (init_done_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_d_o      (mem_d_o),
        .mem_d_i      (mem_d_i)
    );

    // RAM model: output is meaningful only the cycle after a read, junk otherwise
    logic [31:0] ram [16];
    int          cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_d_o[8*b +: 8];
        end
        if (mem_en_o && mem_we_o == 4'h0) mem_d_i <= ram[mem_addr_o];
        else                              mem_d_i <= 32'hBAD0_0000 | 32'(cyc);
    end

    task automatic idle_inputs();
        iob_valid_i  = 1'b0;
        iob_addr_i   = '0;
        iob_wdata_i  = '0;
        iob_wstrb_i  = '0;
        iob_rready_i = 1'b1;
        init_i       = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_i       = 1'b1;
            iob_valid_i = 1'b1;
            #1;
            checks++;
            if ({iob_ready_o, iob_rvalid_o, mem_en_o, mem_we_o, init_done_o} !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: rdy/rv/en/we/done=%b want 00000000", i,
                         {iob_ready_o, iob_rvalid_o, mem_en_o, mem_we_o, init_done_o});
            end
        end
    endtask

    // Clear sequence: one write per cycle, addresses 0..15, then RUN
    task automatic run_clear(input string tag);
        int writes = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_i = 1'b0;
            #1;
            checks++;
            if ({mem_en_o, mem_we_o, mem_addr_o, mem_d_o, iob_ready_o, init_done_o}
                !== {1'b1, 4'hF, 4'(i), INIT_V, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s_step%0d: en=%b we=%h addr=%0d d=%h rdy=%b done=%b want en=1 we=f addr=%0d d=%h rdy=0 done=0",
                         tag, i, mem_en_o, mem_we_o, mem_addr_o, mem_d_o, iob_ready_o, init_done_o, i, INIT_V);
            end
            if (mem_en_o && mem_we_o == 4'hF) writes++;
        end
        checks++;
        if (writes != 16) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want 16", tag, writes);
        end
        @(negedge clk);
        #1;
        checks++;
        if (init_done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: init_done=%b want 1", tag, init_done_o);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
        #1;
        checks++;
        if ({iob_ready_o, mem_en_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, s, a[5:2]}) begin
            errors++;
            $display("FAIL write_accept a=%h: rdy=%b en=%b we=%h addr=%h want 1 1 %h %h",
                     a, iob_ready_o, mem_en_o, mem_we_o, mem_addr_o, s, a[5:2]);
        end
        @(negedge clk);
        iob_valid_i = 1'b0; iob_wstrb_i = '0;
        #1;
        checks++;
        if (iob_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid a=%h: rvalid=%b want 0", a, iob_rvalid_o);
        end
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wstrb_i = '0; iob_rready_i = 1'b1;
        #1;
        checks++;
        if ({iob_ready_o, mem_en_o, mem_we_o} !== 6'b110000) begin
            errors++;
            $display("FAIL %s_accept: rdy=%b en=%b we=%h want 1 1 0", tag, iob_ready_o, mem_en_o, mem_we_o);
        end
        @(negedge clk);
        iob_valid_i = 1'b0;
        #1;
        checks++;
        if ({iob_rvalid_o, iob_rdata_o} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL %s_data: rvalid=%b rdata=%h want 1 %h", tag, iob_rvalid_o, iob_rdata_o, exp);
        end
    endtask

    task automatic test_clear_contents();
        for (int i = 0; i < 16; i++) do_read(6'(i * 4), INIT_V, "clear_content");
    endtask

    task automatic test_partial_write();
        do_write(6'h08, 32'h1122_3344, 4'hF);
        do_write(6'h08, 32'hFFFF_FFFF, 4'b0100);
        do_read(6'h08, 32'h11FF_3344, "partial");
    endtask

    task automatic test_raw_consecutive();
        @(negedge clk);
        iob_valid_i = 1'b1; iob_addr_i = 6'h0C; iob_wdata_i = 32'hDEAD_BEEF; iob_wstrb_i = 4'hF;
        @(negedge clk);
        iob_wstrb_i = 4'h0;
        @(negedge clk);
        iob_valid_i = 1'b0;
        #1;
        checks++;
        if ({iob_rvalid_o, iob_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL raw_consecutive: rvalid=%b rdata=%h want 1 deadbeef", iob_rvalid_o, iob_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  addrs [3] = '{6'h00, 6'h04, 6'h08};
        logic [31:0] exps  [3] = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h11FF_3344};
        do_write(6'h00, 32'h0000_AAAA, 4'hF);
        do_write(6'h04, 32'h0000_BBBB, 4'hF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            iob_valid_i = (c < 3); iob_addr_i = addrs[c % 3]; iob_wstrb_i = '0;
            #1;
            if (c < 3) begin
                checks++;
                if (iob_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c%0d: rdy=%b want 1", c, iob_ready_o);
                end
            end
            checks++;
            if (c >= 1 && c <= 3) begin
                if ({iob_rvalid_o, iob_rdata_o} !== {1'b1, exps[c-1]}) begin
                    errors++;
                    $display("FAIL b2b_data c%0d: rvalid=%b rdata=%h want 1 %h", c, iob_rvalid_o, iob_rdata_o, exps[c-1]);
                end
            end else if (iob_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_rvalid_idle c%0d: rvalid=%b want 0", c, iob_rvalid_o);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        iob_valid_i = 1'b1; iob_addr_i = 6'h04; iob_wstrb_i = '0; iob_rready_i = 1'b0;
        #1;
        checks++;
        if (iob_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_first_accept: rdy=%b want 1", iob_ready_o);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            iob_addr_i = 6'h08;
            #1;
            checks++;
            if ({iob_ready_o, mem_en_o, iob_rvalid_o, iob_rdata_o} !== {1'b0, 1'b0, 1'b1, 32'h0000_BBBB}) begin
                errors++;
                $display("FAIL stall_hold c%0d: rdy=%b en=%b rvalid=%b rdata=%h want 0 0 1 0000bbbb",
                         c, iob_ready_o, mem_en_o, iob_rvalid_o, iob_rdata_o);
            end
        end
        @(negedge clk);
        iob_rready_i = 1'b1;
        #1;
        checks++;
        if ({iob_ready_o, mem_en_o, iob_rvalid_o, iob_rdata_o} !== {1'b1, 1'b1, 1'b1, 32'h0000_BBBB}) begin
            errors++;
            $display("FAIL stall_release: rdy=%b en=%b rvalid=%b rdata=%h want 1 1 1 0000bbbb",
                     iob_ready_o, mem_en_o, iob_rvalid_o, iob_rdata_o);
        end
        @(negedge clk);
        iob_valid_i = 1'b0;
        #1;
        checks++;
        if ({iob_rvalid_o, iob_rdata_o} !== {1'b1, 32'h11FF_3344}) begin
            errors++;
            $display("FAIL stall_next_read: rvalid=%b rdata=%h want 1 11ff3344", iob_rvalid_o, iob_rdata_o);
        end
    endtask

    task automatic test_init_while_stalled();
        @(negedge clk);
        iob_valid_i = 1'b1; iob_addr_i = 6'h00; iob_wstrb_i = '0; iob_rready_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            init_i       = 1'b1;
            iob_rready_i = (c >= 3);
            #1;
            checks++;
            if ({iob_ready_o, mem_en_o, init_done_o} !== 3'b001) begin
                errors++;
                $display("FAIL init_wait c%0d: rdy=%b en=%b done=%b want 0 0 1", c, iob_ready_o, mem_en_o, init_done_o);
            end
            if (c <= 3) begin
                checks++;
                if ({iob_rvalid_o, iob_rdata_o} !== {1'b1, 32'h0000_AAAA}) begin
                    errors++;
                    $display("FAIL init_rsp c%0d: rvalid=%b rdata=%h want 1 0000aaaa", c, iob_rvalid_o, iob_rdata_o);
                end
            end
        end
        run_clear("init_clear");
        iob_valid_i = 1'b0;
        checks++;
        if (iob_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL init_single_shot: rdy=%b want 1 with init_i still high", iob_ready_o);
        end
        @(negedge clk);
        init_i = 1'b0;
        do_read(6'h00, INIT_V, "init_refilled");
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        init_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            init_i = 1'b0;
            #1;
            checks++;
            if ({mem_en_o, mem_addr_o} !== {1'b1, 4'(i)}) begin
                errors++;
                $display("FAIL midclr_pre%0d: en=%b addr=%0d want 1 %0d", i, mem_en_o, mem_addr_o, i);
            end
        end
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({iob_ready_o, iob_rvalid_o, mem_en_o, mem_we_o, init_done_o} !== 8'h00) begin
            errors++;
            $display("FAIL midclr_reset_outputs: rdy/rv/en/we/done=%b want 00000000",
                     {iob_ready_o, iob_rvalid_o, mem_en_o, mem_we_o, init_done_o});
        end
        run_clear("midclr_restart");
        do_read(6'h3C, INIT_V, "midclr_final");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        for (int i = 0; i < 16; i++) ram[i] = '0;
        test_reset();
        idle_inputs();
        run_clear("reset_clear");
        test_clear_contents();
        test_partial_write();
        test_raw_consecutive();
        test_back_to_back();
        test_stall();
        test_init_while_stalled();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
